// File: rtl/wm_motor_pkg.sv
// Shared types and constants for the wash-drum motor speed sequencer.
// Holds the sequencer state enum, duty/direction constants and the ramp decision rule.
package wm_motor_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RAMP_UP   = 3'd1,
    ST_RAMP_DOWN = 3'd2,
    ST_DEADTIME  = 3'd3,
    ST_ESTOP     = 3'd4
  } motor_state_e;

  localparam logic [1:0] DUTY_OFF  = 2'd0;
  localparam logic [1:0] DUTY_LOW  = 2'd1;
  localparam logic [1:0] DUTY_MID  = 2'd2;
  localparam logic [1:0] DUTY_HIGH = 2'd3;

  localparam logic DIR_CW  = 1'b0;
  localparam logic DIR_CCW = 1'b1;

  function automatic logic [1:0] duty_inc(input logic [1:0] d);
    return (d == DUTY_HIGH) ? DUTY_HIGH : d + 2'd1;
  endfunction

  function automatic logic [1:0] duty_dec(input logic [1:0] d);
    return (d == DUTY_OFF) ? DUTY_OFF : d - 2'd1;
  endfunction

  // Where the sequencer has to go from (duty, dir) to reach the target.
  // A direction change always drains to zero first, then waits out the dead-time.
  function automatic motor_state_e decide(input logic [1:0] duty,
                                          input logic       dir,
                                          input logic [1:0] tgt_spd,
                                          input logic       tgt_dir);
    if (tgt_dir != dir) return (duty != DUTY_OFF) ? ST_RAMP_DOWN : ST_DEADTIME;
    if (duty < tgt_spd) return ST_RAMP_UP;
    if (duty > tgt_spd) return ST_RAMP_DOWN;
    return ST_IDLE;
  endfunction

endpackage

// File: rtl/interval_timer.sv
// Free-running dwell counter: counts 0..terminal_i while enabled and pulses expire_o
// for the cycle the count sits at terminal_i; restart or disable returns it to 0.
module interval_timer #(
  parameter int W = 2
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         restart_i,
  input  logic         enable_i,
  input  logic [W-1:0] terminal_i,
  output logic         expire_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (restart_i || !enable_i) begin
      cnt_d = '0;
    end else if (cnt_q == terminal_i) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = enable_i && (cnt_q == terminal_i);

endmodule

// File: rtl/motor_speed_ramp.sv
// Soft-start/soft-stop sequencer feeding the PWM duty select: steps the duty one level
// per dwell interval, inserts a dead-time at zero before any direction flip, and honours e-stop.
module motor_speed_ramp
  import wm_motor_pkg::*;
#(
  parameter int STEP_CYC = 200000,
  parameter int DEAD_CYC = 500000
) (
  input  logic       i_1Mhz_clk,
  input  logic       i_rst,
  input  logic       i_req_valid,
  input  logic [1:0] i_speed_req,
  input  logic       i_dir_req,
  input  logic       i_estop,
  output logic [1:0] o_pwm_duty,
  output logic       o_motor_dir,
  output logic       o_busy,
  output logic       o_at_speed,
  output logic [2:0] o_dbg_state
);

  localparam int MAX_CYC = (STEP_CYC > DEAD_CYC) ? STEP_CYC : DEAD_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC);

  motor_state_e state_q, state_d, cand;
  logic [1:0]   duty_q, duty_d;
  logic         dir_q, dir_d;
  logic [1:0]   tgt_spd_q, tgt_spd_d;
  logic         tgt_dir_q, tgt_dir_d;

  logic             tmr_restart;
  logic             tmr_enable;
  logic             tmr_expire;
  logic [CNT_W-1:0] tmr_terminal;

  // Decisions use the registered target, so a request latched at one edge
  // takes effect on the following edge.
  always_comb begin
    state_d   = state_q;
    duty_d    = duty_q;
    dir_d     = dir_q;
    tgt_spd_d = tgt_spd_q;
    tgt_dir_d = tgt_dir_q;
    cand      = decide(duty_q, dir_q, tgt_spd_q, tgt_dir_q);

    if (i_estop) begin
      state_d   = ST_ESTOP;
      duty_d    = DUTY_OFF;
      tgt_spd_d = DUTY_OFF;
      tgt_dir_d = dir_q;
    end else begin
      if (i_req_valid) begin
        tgt_spd_d = i_speed_req;
        tgt_dir_d = i_dir_req;
      end
      if (state_q == ST_ESTOP) begin
        state_d = ST_IDLE;
      end else if (cand != state_q) begin
        state_d = cand;
      end else if (tmr_expire) begin
        case (state_q)
          ST_RAMP_UP: begin
            duty_d  = duty_inc(duty_q);
            state_d = decide(duty_d, dir_q, tgt_spd_q, tgt_dir_q);
          end
          ST_RAMP_DOWN: begin
            duty_d  = duty_dec(duty_q);
            state_d = decide(duty_d, dir_q, tgt_spd_q, tgt_dir_q);
          end
          ST_DEADTIME: begin
            dir_d   = tgt_dir_q;
            state_d = decide(duty_q, tgt_dir_q, tgt_spd_q, tgt_dir_q);
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge i_1Mhz_clk) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      duty_q    <= DUTY_OFF;
      dir_q     <= DIR_CW;
      tgt_spd_q <= DUTY_OFF;
      tgt_dir_q <= DIR_CW;
    end else begin
      state_q   <= state_d;
      duty_q    <= duty_d;
      dir_q     <= dir_d;
      tgt_spd_q <= tgt_spd_d;
      tgt_dir_q <= tgt_dir_d;
    end
  end

  // Any state change starts the new phase with a fresh dwell count.
  assign tmr_restart  = (state_d != state_q);
  assign tmr_enable   = (state_q == ST_RAMP_UP) || (state_q == ST_RAMP_DOWN) ||
                        (state_q == ST_DEADTIME);
  assign tmr_terminal = (state_q == ST_DEADTIME) ? CNT_W'(DEAD_CYC - 1) : CNT_W'(STEP_CYC - 1);

  interval_timer #(
    .W(CNT_W)
  ) u_timer (
    .clk_i      (i_1Mhz_clk),
    .rst_i      (i_rst),
    .restart_i  (tmr_restart),
    .enable_i   (tmr_enable),
    .terminal_i (tmr_terminal),
    .expire_o   (tmr_expire)
  );

  assign o_pwm_duty  = duty_q;
  assign o_motor_dir = dir_q;
  assign o_busy      = tmr_enable;
  assign o_at_speed  = (state_q == ST_IDLE) && (duty_q == tgt_spd_q) && (dir_q == tgt_dir_q);
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_motor_speed_ramp.sv
// Directed bench for motor_speed_ramp with STEP_CYC=4, DEAD_CYC=8: a countdown-based
// behavioural model is compared every cycle, plus hand-computed checkpoints.
module tb_motor_speed_ramp;

  localparam int STEP = 4;
  localparam int DEAD = 8;

  localparam int M_IDLE = 0;
  localparam int M_UP   = 1;
  localparam int M_DOWN = -1;
  localparam int M_DEAD = 2;
  localparam int M_STOP = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req = 1'b0;
  logic [1:0] spd = 2'd0;
  logic       dreq = 1'b0;
  logic       estop = 1'b0;
  logic [1:0] duty;
  logic       dir;
  logic       busy;
  logic       at_speed;
  logic [2:0] dbg_state;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // model state: duty/dir, latched target, motion mode, cycles left in current dwell
  int m_duty = 0, m_dir = 0, m_tspd = 0, m_tdir = 0, m_mode = M_IDLE, m_left = 0;

  always #5 clk = ~clk;

  motor_speed_ramp #(
    .STEP_CYC(STEP),
    .DEAD_CYC(DEAD)
  ) dut (
    .i_1Mhz_clk  (clk),
    .i_rst       (rst),
    .i_req_valid (req),
    .i_speed_req (spd),
    .i_dir_req   (dreq),
    .i_estop     (estop),
    .o_pwm_duty  (duty),
    .o_motor_dir (dir),
    .o_busy      (busy),
    .o_at_speed  (at_speed),
    .o_dbg_state (dbg_state)
  );

  function automatic int plan(input int d, input int r, input int ts, input int td);
    if (td != r) return (d > 0) ? M_DOWN : M_DEAD;
    if (d < ts) return M_UP;
    if (d > ts) return M_DOWN;
    return M_IDLE;
  endfunction

  always @(posedge clk) begin
    int d, r, ts, td, mode, left, p;
    d = m_duty; r = m_dir; ts = m_tspd; td = m_tdir; mode = m_mode; left = m_left;
    if (rst) begin
      d = 0; r = 0; ts = 0; td = 0; mode = M_IDLE; left = 0;
    end else if (estop) begin
      mode = M_STOP; d = 0; ts = 0; td = r;
    end else begin
      if (mode == M_STOP) begin
        mode = M_IDLE;
      end else begin
        p = plan(d, r, ts, td);
        if (p != mode) begin
          mode = p;
          left = (p == M_DEAD) ? DEAD : STEP;
        end else if (mode == M_UP || mode == M_DOWN) begin
          left = left - 1;
          if (left == 0) begin
            d = d + mode;
            mode = plan(d, r, ts, td);
            left = (mode == M_DEAD) ? DEAD : STEP;
          end
        end else if (mode == M_DEAD) begin
          left = left - 1;
          if (left == 0) begin
            r = td;
            mode = plan(d, r, ts, td);
            left = STEP;
          end
        end
      end
      if (req) begin
        ts = int'(spd);
        td = int'(dreq);
      end
    end
    m_duty <= d; m_dir <= r; m_tspd <= ts; m_tdir <= td; m_mode <= mode; m_left <= left;
  end

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model_duty", {2'b00, duty}, 4'(m_duty));
      chk("model_dir", {3'b000, dir}, 4'(m_dir));
      chk("model_busy", {3'b000, busy},
          4'((m_mode == M_UP || m_mode == M_DOWN || m_mode == M_DEAD) ? 1 : 0));
      chk("model_at_speed", {3'b000, at_speed},
          4'((m_mode == M_IDLE && m_duty == m_tspd && m_dir == m_tdir) ? 1 : 0));
    end
  end

  task automatic wait_edges(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Request is sampled at the next rising edge; returns just after that edge.
  task automatic send_req(input logic [1:0] s, input logic d);
    req = 1'b1; spd = s; dreq = d;
    @(negedge clk);
    req = 1'b0;
  endtask

  task automatic chk_out(input string tag, input int e_duty, input int e_dir,
                         input int e_busy, input int e_at);
    chk({tag, "_duty"}, {2'b00, duty}, 4'(e_duty));
    chk({tag, "_dir"}, {3'b000, dir}, 4'(e_dir));
    chk({tag, "_busy"}, {3'b000, busy}, 4'(e_busy));
    chk({tag, "_at_speed"}, {3'b000, at_speed}, 4'(e_at));
  endtask

  initial begin
    // reset held for three edges
    @(negedge clk);
    cmp_en = 1'b1;
    wait_edges(2);
    chk_out("reset", 0, 0, 0, 1);
    rst = 1'b0;
    wait_edges(1);
    chk_out("post_reset", 0, 0, 0, 1);

    // soft start to 3/CW
    send_req(2'd3, 1'b0);
    wait_edges(4);  chk_out("up_e4", 0, 0, 1, 0);
    wait_edges(1);  chk_out("up_e5", 1, 0, 1, 0);
    wait_edges(4);  chk_out("up_e9", 2, 0, 1, 0);
    wait_edges(3);  chk_out("up_e12", 2, 0, 1, 0);
    wait_edges(1);  chk_out("up_e13", 3, 0, 0, 1);

    // reversal 3/CW -> 2/CCW through zero and dead-time
    send_req(2'd2, 1'b1);
    wait_edges(5);  chk_out("rev_e5", 2, 0, 1, 0);
    wait_edges(8);  chk_out("rev_e13", 0, 0, 1, 0);
    wait_edges(7);  chk_out("rev_e20", 0, 0, 1, 0);
    wait_edges(1);  chk_out("rev_e21", 0, 1, 1, 0);
    wait_edges(4);  chk_out("rev_e25", 1, 1, 1, 0);
    wait_edges(4);  chk_out("rev_e29", 2, 1, 0, 1);

    // soft stop, same direction
    send_req(2'd0, 1'b1);
    wait_edges(9);  chk_out("stop_e9", 0, 1, 0, 1);

    // ramp-up aborted into ramp-down once duty reaches 2
    send_req(2'd3, 1'b1);
    wait_edges(9);  chk_out("abort_up_e9", 2, 1, 1, 0);
    send_req(2'd0, 1'b1);
    wait_edges(4);  chk_out("abort_j4", 2, 1, 1, 0);
    wait_edges(1);  chk_out("abort_j5", 1, 1, 1, 0);
    wait_edges(4);  chk_out("abort_j9", 0, 1, 0, 1);

    // e-stop mid ramp with a coincident request that must be dropped
    send_req(2'd3, 1'b1);
    wait_edges(10); chk_out("es_pre", 2, 1, 1, 0);
    estop = 1'b1;
    wait_edges(1);  chk_out("es_hit", 0, 1, 0, 0);
    send_req(2'd1, 1'b1);
    wait_edges(1);
    estop = 1'b0;
    wait_edges(1);  chk_out("es_release", 0, 1, 0, 1);
    wait_edges(6);  chk_out("es_after", 0, 1, 0, 1);

    // reset in the middle of a dead-time
    send_req(2'd1, 1'b0);
    wait_edges(4);  chk_out("dt_mid", 0, 1, 1, 0);
    rst = 1'b1;
    wait_edges(1);  chk_out("dt_reset", 0, 0, 0, 1);
    rst = 1'b0;
    send_req(2'd0, 1'b0);
    wait_edges(3);  chk_out("noop_req", 0, 0, 0, 1);

    wait_edges(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/motor_speed_ramp.md
# motor_speed_ramp

Soft-start and soft-stop sequencer for the wash-drum motor, placed directly upstream of the PWM generator. It accepts a requested speed level and rotation direction from the MCU-facing command logic and drives the 2-bit duty-level select consumed by the PWM generator. The duty level moves one step at a time at a fixed dwell interval. Every direction reversal passes through zero speed and a dead-time before the direction output flips. An emergency-stop input forces the duty level to zero immediately.

## Interface
- STEP_CYC, 200000: clock cycles per duty step (200 ms at 1 MHz); must be ≥2.
- DEAD_CYC, 500000: clock cycles held at duty 0 before a direction flip; must be ≥2.
- i_1Mhz_clk  in  1  the single clock; all logic is on the rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_req_valid  in  1  single-cycle strobe; latches i_speed_req and i_dir_req as the new target.
- i_speed_req  in  2  target duty level (0 = off … 3 = max).
- i_dir_req  in  1  target direction (0 = CW, 1 = CCW).
- i_estop  in  1  level-sensitive emergency stop.
- o_pwm_duty  out  2  current duty level, feeds the PWM generator's duty select. Registered.
- o_motor_dir  out  1  current direction. Registered.
- o_busy  out  1  high in RAMP_UP, RAMP_DOWN and DEADTIME.
- o_at_speed  out  1  high when in IDLE with duty == target and dir == target dir.

## Operation
- Reset values:
  - o_pwm_duty = 0, o_motor_dir = 0, o_busy = 0, o_at_speed = 1.
  - Target is 0 / CW; state is IDLE; timer is 0.
- States: IDLE, RAMP_UP, RAMP_DOWN, DEADTIME, ESTOP.
- Request decision, evaluated on every accepted request (target latched) and in IDLE:
  - If dir target ≠ o_motor_dir and duty > 0 → RAMP_DOWN toward 0.
  - If dir target ≠ o_motor_dir and duty == 0 → DEADTIME.
  - If dir target matches and duty < target → RAMP_UP.
  - If dir target matches and duty > target → RAMP_DOWN.
  - Otherwise → IDLE.
- RAMP_UP / RAMP_DOWN:
  - Timer counts 0..STEP_CYC-1.
  - On terminal count, duty moves ±1 and the timer reloads to 0.
  - When the new duty equals the ramp goal, re-run the decision: next state is DEADTIME, IDLE, or the opposite ramp.
- DEADTIME:
  - Duty is held at 0; timer counts 0..DEAD_CYC-1.
  - On terminal count, o_motor_dir takes the target dir, then the decision runs (RAMP_UP, or IDLE if target speed is 0).
  - A direction flip always passes through DEADTIME, even if duty was already 0.
- Request while busy:
  - Target is overwritten.
  - If the required state equals the current state, the timer continues.
  - If the state changes (ramp reversal, or a dir change aborting a ramp-up), the timer restarts at 0.
- A request identical to the current duty/dir in IDLE has no effect.
- ESTOP:
  - While i_estop is high, state is ESTOP, duty = 0, target speed is cleared to 0, and dir is held.
  - On release, state goes to IDLE; a fresh request is needed to restart.
- Simultaneous events:
  - i_estop wins over i_req_valid; the request is dropped.
  - i_rst wins over everything.
- Duty arithmetic is saturating 2-bit; no wrap from 3 to 0 or from 0 to 3.

## Timing
- A request sampled at edge k enters its ramp at edge k+1 with timer 0.
- The first duty change is visible after edge k+STEP_CYC+1; each subsequent step follows STEP_CYC cycles later.
- o_busy rises at edge k+1 and falls on the same edge the final duty step appears.
- o_at_speed rises on that same edge.
- Estop asserted at edge k gives o_pwm_duty = 0 and o_busy = 0 after edge k.
- Reset asserted mid-ramp returns all outputs to their reset values after the next edge.

## Structure
- Shared package wm_motor_pkg holds:
  - the state enum;
  - duty constants DUTY_OFF = 0, DUTY_LOW = 1, DUTY_MID = 2, DUTY_HIGH = 3;
  - direction constants DIR_CW = 0, DIR_CCW = 1.
- Sub-module interval_timer, instantiated once:
  - Inputs: restart, enable, terminal value.
  - Output: a one-cycle expire pulse.
  - Counter width is $clog2(max(STEP_CYC, DEAD_CYC)).

## Test plan
All scenarios run with STEP_CYC = 4 and DEAD_CYC = 8.
- Reset held 3 cycles → duty 0, dir 0, busy 0, at_speed 1.
- Request speed 3, dir 0 at edge 0 → duty 1/2/3 after edges 5/9/13; busy is high over edges 1–12 and falls at edge 13, when at_speed rises.
- From steady 3/CW, request 2/CCW → duty 2/1/0 at 4-cycle spacing, 8 cycles at 0, dir flips to 1, then duty 1/2 at 4-cycle spacing, then at_speed = 1.
- Ramp-up to 3, request 0 right after duty reaches 2 → state RAMP_DOWN, timer restarts, duty 1 four cycles later, then 0, then IDLE.
- Estop while duty = 2 mid-ramp → duty 0 on the next edge, dir unchanged. After release, duty stays 0 until a new request. A request coincident with estop is ignored.
- i_rst pulsed mid-DEADTIME → all outputs at reset values after the next edge. A request of 0/CW afterwards has no effect: busy stays 0.
